// File: rtl/decode_pkg.sv
// Shared decode/execute types: fetched and decoded instruction payloads, op classes,
// RV32I opcodes and immediate extraction helpers.
package decode_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        INSTR_INVAL,
        INSTR_LUI,
        INSTR_AUIPC,
        INSTR_JAL,
        INSTR_JALR,
        INSTR_BRANCH,
        INSTR_LOAD,
        INSTR_STORE,
        INSTR_OP_IMM,
        INSTR_OP
    } instr_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetched_instr_t;

    typedef struct packed {
        instr_op_e        op;
        logic [XLEN-1:0]  pc;
        logic [ILEN-1:0]  raw;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [XLEN-1:0]  imm;
    } decoded_instr_t;

    // Immediate formats, all sign-extended from instruction bit 31.
    function automatic logic [XLEN-1:0] imm_i(input logic [ILEN-1:0] ins);
        return {{(XLEN-12){ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [ILEN-1:0] ins);
        return {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [ILEN-1:0] ins);
        return {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [ILEN-1:0] ins);
        return {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [ILEN-1:0] ins);
        return {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_instr_decoder.sv
// Combinational RV32I decoder: classifies a fetched word, extracts gated register
// indices and the format-specific sign-extended immediate.
module instr_decoder
    import decode_pkg::*;
(
    input  fetched_instr_t fetched_i,
    output decoded_instr_t dec_c_o
);

    logic [ILEN-1:0] ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    instr_op_e       op;

    assign ins = fetched_i.instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    // Op classification including funct3/funct7 legality.
    always_comb begin
        op = INSTR_INVAL;
        if (ins[1:0] == 2'b11) begin
            case (opc)
                OPC_LUI:    op = INSTR_LUI;
                OPC_AUIPC:  op = INSTR_AUIPC;
                OPC_JAL:    op = INSTR_JAL;
                OPC_JALR:   if (f3 == 3'b000) op = INSTR_JALR;
                OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) op = INSTR_BRANCH;
                OPC_LOAD: begin
                    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101) op = INSTR_LOAD;
                end
                OPC_STORE:  if (f3 <= 3'b010) op = INSTR_STORE;
                OPC_OP_IMM: begin
                    case (f3)
                        3'b001:  if (f7 == FUNCT7_ZERO) op = INSTR_OP_IMM;
                        3'b101:  if (f7 == FUNCT7_ZERO || f7 == FUNCT7_ALT) op = INSTR_OP_IMM;
                        default: op = INSTR_OP_IMM;
                    endcase
                end
                OPC_OP: begin
                    if (f7 == FUNCT7_ZERO ||
                        (f7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101))) op = INSTR_OP;
                end
                default: op = INSTR_INVAL;
            endcase
        end
    end

    // Field gating and immediate selection; invalid words keep only pc and raw.
    always_comb begin
        dec_c_o     = '0;
        dec_c_o.pc  = fetched_i.pc;
        dec_c_o.raw = ins;
        dec_c_o.op  = op;
        if (op != INSTR_INVAL) begin
            dec_c_o.funct3 = f3;
            dec_c_o.funct7 = f7;
            if (op != INSTR_BRANCH && op != INSTR_STORE) dec_c_o.rd = ins[11:7];
            if (op != INSTR_LUI && op != INSTR_AUIPC && op != INSTR_JAL) dec_c_o.rs1 = ins[19:15];
            if (op == INSTR_OP || op == INSTR_BRANCH || op == INSTR_STORE) dec_c_o.rs2 = ins[24:20];
            case (op)
                INSTR_LUI, INSTR_AUIPC:               dec_c_o.imm = imm_u(ins);
                INSTR_JAL:                            dec_c_o.imm = imm_j(ins);
                INSTR_JALR, INSTR_LOAD, INSTR_OP_IMM: dec_c_o.imm = imm_i(ins);
                INSTR_BRANCH:                         dec_c_o.imm = imm_b(ins);
                INSTR_STORE:                          dec_c_o.imm = imm_s(ins);
                default:                              dec_c_o.imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: decodes fetched words and queues them in an in-order FIFO
// feeding execute; flush drops everything buffered or being accepted.
module decode
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fetched_valid_i,
    output logic           fetched_ready_o,
    input  fetched_instr_t fetched_data_i,
    output logic           decoded_valid_o,
    input  logic           decoded_ready_i,
    output decoded_instr_t decoded_data_o,
    input  logic           flush_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    decoded_instr_t dec_c;
    decoded_instr_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             push, pop;

    instr_decoder u_instr_decoder (
        .fetched_i (fetched_data_i),
        .dec_c_o   (dec_c)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = fetched_valid_i && ready_q && !flush_i;
    assign pop  = valid_q && decoded_ready_i;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        ready_d = (count_d != CNT_W'(DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= dec_c;
        end
    end

    assign fetched_ready_o = ready_q;
    assign decoded_valid_o = valid_q;
    assign decoded_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: hand-computed expected decodes are queued on acceptance
// and compared as execute pops them; directed checks cover backpressure, flush and reset.
module tb_decode;
    import decode_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           fetched_valid_i;
    logic           fetched_ready_o;
    fetched_instr_t fetched_data_i;
    logic           decoded_valid_o;
    logic           decoded_ready_i;
    decoded_instr_t decoded_data_o;
    logic           flush_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        instr_op_e   op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t tbl [18];
    exp_t sb [$];
    exp_t cur_exp;
    exp_t mon_e;
    logic rand_rdy = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    decode #(.DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetched_valid_i (fetched_valid_i),
        .fetched_ready_o (fetched_ready_o),
        .fetched_data_i  (fetched_data_i),
        .decoded_valid_o (decoded_valid_o),
        .decoded_ready_i (decoded_ready_i),
        .decoded_data_o  (decoded_data_o),
        .flush_i         (flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins, input instr_op_e op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
        exp_t e;
        e.pc = pc; e.instr = ins; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        return e;
    endfunction

    // Scoreboard monitor: handshakes sampled mid-cycle, stable across the next rising edge.
    always @(negedge clk) begin
        if (!rst || flush_i) begin
            sb.delete();
        end else begin
            if (decoded_valid_o && decoded_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(decoded_data_o.raw), 64'hdead);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_op",  64'(decoded_data_o.op),  64'(mon_e.op));
                    chk("sb_pc",  64'(decoded_data_o.pc),  64'(mon_e.pc));
                    chk("sb_raw", 64'(decoded_data_o.raw), 64'(mon_e.instr));
                    chk("sb_rd",  64'(decoded_data_o.rd),  64'(mon_e.rd));
                    chk("sb_rs1", 64'(decoded_data_o.rs1), 64'(mon_e.rs1));
                    chk("sb_rs2", 64'(decoded_data_o.rs2), 64'(mon_e.rs2));
                    chk("sb_imm", 64'(decoded_data_o.imm), 64'(mon_e.imm));
                end
            end
            if (fetched_valid_i && fetched_ready_o) sb.push_back(cur_exp);
        end
    end

    // Random backpressure from execute when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) decoded_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; leaves valid high at posedge+1 after acceptance.
    task automatic send(input exp_t e);
        logic ok;
        fetched_valid_i    = 1'b1;
        fetched_data_i.pc  = e.pc;
        fetched_data_i.instr = e.instr;
        cur_exp = e;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fetched_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (sb.size() == 0 && !decoded_valid_o) break;
            @(negedge clk);
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = mk(32'h100, 32'h00500093, INSTR_OP_IMM, 5'd1, 5'd0, 5'd0, 32'h5);
        tbl[1]  = mk(32'h104, 32'h12345137, INSTR_LUI,    5'd2, 5'd0, 5'd0, 32'h12345000);
        tbl[2]  = mk(32'h108, 32'hFE000EE3, INSTR_BRANCH, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        tbl[3]  = mk(32'h10C, 32'h00000000, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[4]  = mk(32'h110, 32'h0200D0B3, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[5]  = mk(32'h114, 32'h002081B3, INSTR_OP,     5'd3, 5'd1, 5'd2, 32'h0);
        tbl[6]  = mk(32'h118, 32'h407302B3, INSTR_OP,     5'd5, 5'd6, 5'd7, 32'h0);
        tbl[7]  = mk(32'h11C, 32'hFE20AC23, INSTR_STORE,  5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
        tbl[8]  = mk(32'h120, 32'h0101A203, INSTR_LOAD,   5'd4, 5'd3, 5'd0, 32'h10);
        tbl[9]  = mk(32'h124, 32'h001000EF, INSTR_JAL,    5'd1, 5'd0, 5'd0, 32'h800);
        tbl[10] = mk(32'h128, 32'h00009067, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[11] = mk(32'h12C, 32'h40315093, INSTR_OP_IMM, 5'd1, 5'd2, 5'd0, 32'h403);
        tbl[12] = mk(32'h130, 32'hFFFFF397, INSTR_AUIPC,  5'd7, 5'd0, 5'd0, 32'hFFFFF000);
        tbl[13] = mk(32'h134, 32'h00002063, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[14] = mk(32'h138, 32'h00003003, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[15] = mk(32'h13C, 32'h40111193, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);
        tbl[16] = mk(32'h140, 32'hFFF280E7, INSTR_JALR,   5'd1, 5'd5, 5'd0, 32'hFFFFFFFF);
        tbl[17] = mk(32'h144, 32'h00500090, INSTR_INVAL,  5'd0, 5'd0, 5'd0, 32'h0);

        rst = 1'b0;
        flush_i = 1'b0;
        fetched_valid_i = 1'b0;
        fetched_data_i = '0;
        decoded_ready_i = 1'b0;
        cur_exp = tbl[0];

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(fetched_ready_o), 64'd0);
        chk("rst_valid", 64'(decoded_valid_o), 64'd0);
        chk("rst_data",  64'(decoded_data_o.raw), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 64'(fetched_ready_o), 64'd0);
        @(negedge clk);
        chk("ready_after_rel", 64'(fetched_ready_o), 64'd1);
        chk("valid_after_rel", 64'(decoded_valid_o), 64'd0);

        // First word: visible one cycle after acceptance.
        @(posedge clk);
        #1;
        send(tbl[0]);
        fetched_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_valid", 64'(decoded_valid_o), 64'd1);
        chk("lat_op",    64'(decoded_data_o.op), 64'(INSTR_OP_IMM));
        chk("lat_imm",   64'(decoded_data_o.imm), 64'h5);
        decoded_ready_i = 1'b1;
        drain("drain_first");

        // Full table stream under random backpressure.
        @(posedge clk);
        #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 18; i++) send(tbl[i]);
        fetched_valid_i = 1'b0;
        drain("drain_stream");
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 decoded_ready_i = 1'b0;

        // Backpressure: three offered, two accepted, third after the first pop.
        @(posedge clk);
        #1;
        fetched_valid_i = 1'b1;
        fetched_data_i.pc = tbl[5].pc; fetched_data_i.instr = tbl[5].instr; cur_exp = tbl[5];
        @(negedge clk);
        chk("bp_ready0", 64'(fetched_ready_o), 64'd1);
        @(posedge clk);
        #1;
        fetched_data_i.pc = tbl[6].pc; fetched_data_i.instr = tbl[6].instr; cur_exp = tbl[6];
        @(negedge clk);
        chk("bp_ready1", 64'(fetched_ready_o), 64'd1);
        chk("bp_head_a", 64'(decoded_data_o.raw), 64'(tbl[5].instr));
        @(posedge clk);
        #1;
        fetched_data_i.pc = tbl[7].pc; fetched_data_i.instr = tbl[7].instr; cur_exp = tbl[7];
        @(negedge clk);
        chk("bp_full", 64'(fetched_ready_o), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_full_hold", 64'(fetched_ready_o), 64'd0);
        @(posedge clk);
        #1 decoded_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_no_comb_ready", 64'(fetched_ready_o), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(fetched_ready_o), 64'd1);
        chk("bp_head_b", 64'(decoded_data_o.raw), 64'(tbl[6].instr));
        @(posedge clk);
        #1 fetched_valid_i = 1'b0;
        drain("drain_bp");
        decoded_ready_i = 1'b0;

        // Flush while full with a word offered and a pop requested.
        @(posedge clk);
        #1;
        send(tbl[8]);
        send(tbl[9]);
        fetched_data_i.pc = tbl[10].pc; fetched_data_i.instr = tbl[10].instr; cur_exp = tbl[10];
        flush_i = 1'b1;
        decoded_ready_i = 1'b1;
        @(negedge clk);
        chk("fl_full", 64'(fetched_ready_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        fetched_valid_i = 1'b0;
        decoded_ready_i = 1'b0;
        @(negedge clk);
        chk("fl_valid", 64'(decoded_valid_o), 64'd0);
        chk("fl_ready", 64'(fetched_ready_o), 64'd1);
        @(posedge clk);
        #1;
        send(tbl[12]);
        fetched_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_new_valid", 64'(decoded_valid_o), 64'd1);
        chk("fl_new_raw",   64'(decoded_data_o.raw), 64'(tbl[12].instr));
        decoded_ready_i = 1'b1;
        drain("drain_flush");
        decoded_ready_i = 1'b0;

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        send(tbl[1]);
        send(tbl[2]);
        fetched_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mrst_valid", 64'(decoded_valid_o), 64'd0);
        chk("mrst_ready", 64'(fetched_ready_o), 64'd0);
        chk("mrst_data",  64'(decoded_data_o.raw), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mrst_ready_rel", 64'(fetched_ready_o), 64'd1);
        chk("mrst_valid_rel", 64'(decoded_valid_o), 64'd0);

        // Traffic resumes normally after reset.
        @(posedge clk);
        #1;
        decoded_ready_i = 1'b1;
        send(tbl[16]);
        send(tbl[11]);
        fetched_valid_i = 1'b0;
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
